cordic_io_seq: RTL
==================

# cordic_io_seq

Request-side sequencer placed directly upstream of the CORDIC control unit and datapath. It accepts one angle per transaction over a valid/ready handshake and folds the angle into the convergence range [-90°, 90°). It then pulses `bgn` to the control unit, waits for `fin`, applies the quadrant sign correction to the cos/sin results and holds them on a valid/ready output port.

## Interface
- `W`, 16: angle and result width. Angle is binary-angle (full circle = 2^W); results are signed.
- `TMO`, 24: watchdog limit, in cycles, from `bgn` to `fin`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_vld` in 1: request valid.
- `in_rdy` out 1: request ready.
- `in_ang` in W: request angle.
- `bgn` out 1: start pulse to the control unit.
- `z0` out W: reduced angle to the datapath; valid from the `bgn` cycle until `fin`.
- `fin` in 1: done pulse from the control unit.
- `cos_in` in W: datapath X result; sampled when `fin`=1.
- `sin_in` in W: datapath Y result; sampled when `fin`=1.
- `out_vld` out 1: result valid.
- `out_rdy` in 1: result ready.
- `out_cos` out W: corrected result.
- `out_sin` out W: corrected result.
- `out_err` out 1: result produced by watchdog expiry; qualified by `out_vld`.

## Operation
- FSM with states IDLE, START, BUSY, DONE.
  - IDLE: `in_rdy`=1. On `in_vld`: register `z0` and `flip`, then go to START.
  - START: `bgn`=1 for exactly one cycle, clear the watchdog, go to BUSY.
  - BUSY: on `fin`, register the corrected results, `out_err`=0, go to DONE. If the watchdog reaches `TMO` first, results = 0, `out_err`=1, go to DONE.
  - DONE: `out_vld`=1 and outputs held stable. On `out_rdy`, go to IDLE.
- Quadrant map (q = `in_ang[W-1:W-2]`):
  - q=00 or q=11: `z0` = `in_ang`, `flip`=0.
  - q=01 or q=10: `z0` = `in_ang` + 2^(W-1) modulo 2^W, `flip`=1.
- Correction when `flip`=1: `out_cos` = -`cos_in` and `out_sin` = -`sin_in`, two's complement. Negating -2^(W-1) saturates to 2^(W-1)-1.
- A `fin` arriving outside BUSY is ignored.
- If `fin` and watchdog expiry occur in the same cycle, `fin` wins.
- Reset values: state IDLE; `in_rdy`=1 (combinational from IDLE); `bgn`=0; `out_vld`=0; `out_err`=0; `z0`, `out_cos`, `out_sin` = 0.
- Reset mid-transaction discards the transaction; no `bgn` is reissued.

## Timing
- Handshake rules:
  - Transfer occurs on a rising edge with vld=1 and rdy=1.
  - `out_vld` stays high until accepted.
  - `out_cos`, `out_sin` and `out_err` do not change while `out_vld`=1 and `out_rdy`=0.
- Request accepted at edge N → `bgn` high during cycle N+1 → BUSY from N+2.
- `fin` sampled at edge M → `out_vld` high from cycle M+1.
- Result accepted at edge K → `in_rdy` high in cycle K+1. No overlap between transactions; throughput is one transaction per (control-unit latency + 4) cycles.
- Watchdog counts BUSY cycles. On expiry at count `TMO`, `out_vld` rises the next cycle.

## Configuration
- `CORDIC_SEQ_QUAD_EN` defined: the quadrant map and sign correction are as above.
- Not defined:
  - `z0` = `in_ang` unmodified and `flip` is forced to 0.
  - Results pass through uncorrected; the saturation logic is absent.
  - Valid input range is then the caller's responsibility.

## Structure
- Package `cordic_pkg` holds:
  - the state encoding (IDLE/START/BUSY/DONE);
  - the default `W`;
  - the quadrant constants `Q_PASS0`=2'b00, `Q_PASS3`=2'b11;
  - the half-turn constant 2^(W-1).
- Sub-module `cordic_quad_map`: combinational angle fold plus saturating negate, parameterised by `W`. It is instantiated once and compiled out with the macro.
- The FSM and watchdog remain in `cordic_io_seq`.

## Test plan
- W=16, macro on, `in_ang`=0x2000 → `z0`=0x2000, one-cycle `bgn` at N+1; `fin` with cos/sin=0x1000/0x2000 → `out_cos`=0x1000, `out_sin`=0x2000, `out_err`=0.
- `in_ang`=0x6000 → `z0`=0xE000; `fin` with 0x1000/0x2000 → `out_cos`=0xF000, `out_sin`=0xE000.
- `in_ang`=0xA000, `cos_in`=0x8000 at `fin` → `out_cos`=0x7FFF (saturated).
- `out_rdy` held 0 for 10 cycles after `out_vld` → outputs stable and `in_rdy`=0 throughout; `in_rdy`=1 the cycle after acceptance.
- `fin` never asserted, `TMO`=24 → `out_vld` with `out_err`=1 and zero results 25 cycles after BUSY entry; a spurious `fin` in IDLE causes no state change.
- `rst` pulsed during BUSY → all outputs reach reset values asynchronously; a subsequent request completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the CORDIC request sequencer.
// FSM encoding, default width, quadrant codes and half-turn constant.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int W_DEF = 16;

  // Quadrants already inside [-90, 90) that need no fold.
  localparam logic [1:0] Q_PASS0 = 2'b00;
  localparam logic [1:0] Q_PASS3 = 2'b11;

  // Half turn (180 degrees) at the default width.
  localparam int unsigned HALF_TURN = 2 ** (W_DEF - 1);

endpackage

// File: rtl/cordic_quad_map.sv
// cordic_quad_map: folds an angle into [-90, 90) and undoes the fold on results.
// Ports: ang -> z0/flip (fold); flip_q + cos_in/sin_in -> cos_out/sin_out.
module cordic_quad_map
  import cordic_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] ang,
  output logic [W-1:0] z0,
  output logic         flip,
  input  logic         flip_q,
  input  logic [W-1:0] cos_in,
  input  logic [W-1:0] sin_in,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out
);

  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SMAX = ~HALF;

  logic [1:0] q;
  assign q = ang[W-1:W-2];

  // Rotating by 180 degrees negates both cos and sin.
  always_comb begin
    flip = 1'b1;
    z0   = ang + HALF;
    unique case (1'b1)
      (q == Q_PASS0),
      (q == Q_PASS3): begin
        flip = 1'b0;
        z0   = ang;
      end
      default: ;
    endcase
  end

  // The most negative value has no positive twin; clamp it.
  function automatic logic [W-1:0] sneg(
    input logic [W-1:0] v
  );
    return (v == HALF) ? SMAX : -v;
  endfunction

  assign cos_out = flip_q ? sneg(cos_in) : cos_in;
  assign sin_out = flip_q ? sneg(sin_in) : sin_in;

endmodule

// File: rtl/cordic_io_seq.sv
// cordic_io_seq: request sequencer in front of the CORDIC control/datapath.
// in_* request -> bgn/z0 to core, fin/cos_in/sin_in back -> out_* result.
// Macro CORDIC_SEQ_QUAD_EN enables quadrant fold and sign correction.
module cordic_io_seq
  import cordic_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_ang,
  output logic         bgn,
  output logic [W-1:0] z0,
  input  logic         fin,
  input  logic [W-1:0] cos_in,
  input  logic [W-1:0] sin_in,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_cos,
  output logic [W-1:0] out_sin,
  output logic         out_err
);

  localparam int            CW    = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  seq_state_t    state;
  logic [CW-1:0] wdog;
  logic [W-1:0]  z0_d;
  logic [W-1:0]  cos_c;
  logic [W-1:0]  sin_c;

  assign in_rdy = (state == IDLE);

`ifdef CORDIC_SEQ_QUAD_EN
  logic flip_d;
  logic flip_q;

  cordic_quad_map #(
    .W(W)
  ) u_map (
    .ang     (in_ang),
    .z0      (z0_d),
    .flip    (flip_d),
    .flip_q  (flip_q),
    .cos_in  (cos_in),
    .sin_in  (sin_in),
    .cos_out (cos_c),
    .sin_out (sin_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_q <= 1'b0;
    end else if (in_rdy && in_vld) begin
      flip_q <= flip_d;
    end
  end
`else
  assign z0_d  = in_ang;
  assign cos_c = cos_in;
  assign sin_c = sin_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wdog    <= '0;
      bgn     <= 1'b0;
      z0      <= '0;
      out_vld <= 1'b0;
      out_cos <= '0;
      out_sin <= '0;
      out_err <= 1'b0;
    end else begin
      bgn <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_vld) begin
            z0    <= z0_d;
            bgn   <= 1'b1;
            state <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= BUSY;
        end
        BUSY: begin
          // fin takes priority over a same-cycle expiry
          if (fin) begin
            out_cos <= cos_c;
            out_sin <= sin_c;
            out_err <= 1'b0;
            out_vld <= 1'b1;
            state   <= DONE;
          end else if (wdog == TMO_C) begin
            out_cos <= '0;
            out_sin <= '0;
            out_err <= 1'b1;
            out_vld <= 1'b1;
            state   <= DONE;
          end else begin
            wdog <= wdog + CW'(1);
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
